// File: rtl/iommu_reg_if_slave.sv
// Register-interface front-end for the IOMMU register file.
// Accepts single-beat read/write requests, decodes them to a register index,
// drives the software-side field strobes for one cycle and returns the result
// over a valid/ready response channel. One transaction is in flight at a time.
module iommu_reg_if_slave #(
  parameter int               NREGS   = 8,
  parameter int               AW      = 5,
  parameter int               DW      = 32,
  parameter logic [NREGS-1:0] RC_MASK = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [AW-1:0]       req_addr_i,
  input  logic                req_write_i,
  input  logic [DW-1:0]       req_wdata_i,
  input  logic [DW/8-1:0]     req_be_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DW-1:0]       rsp_rdata_o,
  output logic                rsp_error_o,
  output logic [NREGS-1:0]    reg_we_o,
  output logic [DW-1:0]       reg_wd_o,
  output logic [NREGS-1:0]    reg_re_o,
  input  logic [NREGS*DW-1:0] reg_qs_i
);

  localparam int IW = AW - 2;
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [AW-1:0]    addr_q;
  logic             write_q;
  logic [DW-1:0]    wdata_q;
  logic [BW-1:0]    be_q;
  logic [DW-1:0]    rdata_q;
  logic             error_q;

  logic [IW-1:0]    idx;
  logic [NREGS-1:0] sel_oh;
  logic [DW-1:0]    sel_qs;
  logic             hit;
  logic             dec_err;
  logic [DW-1:0]    be_mask;
  logic [DW-1:0]    merged_wd;
  logic             in_access;

  assign idx = addr_q[AW-1:2];

  // Decode the captured address into a one-hot select and the selected qs
  always_comb begin
    sel_oh = '0;
    sel_qs = '0;
    hit    = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (idx == IW'(i)) begin
        sel_oh[i] = 1'b1;
        sel_qs    = reg_qs_i[i*DW +: DW];
        hit       = 1'b1;
      end
    end
  end

  assign dec_err = (addr_q[1:0] != 2'b00) || !hit;

  // Expand each byte enable to a full byte of write mask
  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BW; b++) begin
      be_mask[b*8 +: 8] = {8{be_q[b]}};
    end
  end

  assign merged_wd = (sel_qs & ~be_mask) | (wdata_q & be_mask);

  // Strobes are only live in ACCESS and are killed in a reset cycle
  assign in_access = (state_q == ACCESS) && !rst_i;

  // Field strobes derived from the registered state and captured request
  always_comb begin
    reg_we_o = '0;
    reg_re_o = '0;
    reg_wd_o = '0;
    if (in_access && !dec_err) begin
      if (write_q) begin
        reg_wd_o = merged_wd;
        if (be_q != '0) begin
          reg_we_o = sel_oh;
        end
      end else begin
        reg_re_o = sel_oh & RC_MASK;
      end
    end
  end

  // Next-state logic of the IDLE -> ACCESS -> RESP transaction FSM
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture the request on accept and the response in the ACCESS cycle;
  // qs is sampled here so read-clear fields return their pre-clear value
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        addr_q  <= req_addr_i;
        write_q <= req_write_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
      if (state_q == ACCESS) begin
        error_q <= dec_err;
        rdata_q <= (!write_q && !dec_err) ? sel_qs : '0;
      end
    end
  end

  assign req_ready_o = (state_q == IDLE) && !rst_i;
  assign rsp_valid_o = (state_q == RESP) && !rst_i;
  assign rsp_rdata_o = rdata_q;
  assign rsp_error_o = error_q;

endmodule

// File: tb/tb_iommu_reg_if_slave.sv
// Self-checking bench for iommu_reg_if_slave (NREGS=7, register 3 read-clear).
module tb_iommu_reg_if_slave;

  localparam int NREGS = 7;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               req_valid_i;
  logic               req_ready_o;
  logic [AW-1:0]      req_addr_i;
  logic               req_write_i;
  logic [DW-1:0]      req_wdata_i;
  logic [3:0]         req_be_i;
  logic               rsp_valid_o;
  logic               rsp_ready_i;
  logic [DW-1:0]      rsp_rdata_o;
  logic               rsp_error_o;
  logic [NREGS-1:0]   reg_we_o;
  logic [DW-1:0]      reg_wd_o;
  logic [NREGS-1:0]   reg_re_o;
  logic [NREGS*DW-1:0] reg_qs_i;

  logic [DW-1:0] qs_arr [NREGS];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] qsv;
    logic [6:0]  exp_we;
    logic [31:0] exp_wd;
    logic [6:0]  exp_re;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [10];

  iommu_reg_if_slave #(
    .NREGS  (NREGS),
    .AW     (AW),
    .DW     (DW),
    .RC_MASK(7'b0001000)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .req_write_i(req_write_i),
    .req_wdata_i(req_wdata_i),
    .req_be_i   (req_be_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_error_o(rsp_error_o),
    .reg_we_o   (reg_we_o),
    .reg_wd_o   (reg_wd_o),
    .reg_re_o   (reg_re_o),
    .reg_qs_i   (reg_qs_i)
  );

  always #5 clk_i = ~clk_i;

  // Pack the per-register field values into the qs bus
  always_comb begin
    reg_qs_i = '0;
    for (int i = 0; i < NREGS; i++) begin
      reg_qs_i[i*DW +: DW] = qs_arr[i];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // One full transaction with rsp_ready high; entered and left just after a negedge
  task automatic applyStimulus(input vec_t v, input int n);
    for (int i = 0; i < NREGS; i++) qs_arr[i] = 32'h0;
    if (int'(v.addr[4:2]) < NREGS) qs_arr[v.addr[4:2]] = v.qsv;
    req_addr_i  = v.addr;
    req_write_i = v.write;
    req_wdata_i = v.wdata;
    req_be_i    = v.be;
    req_valid_i = 1'b1;
    #1;
    checkOutput($sformatf("v%0d_ready_idle", n), 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput($sformatf("v%0d_we", n), 32'(reg_we_o), 32'(v.exp_we));
    checkOutput($sformatf("v%0d_wd", n), reg_wd_o, v.exp_wd);
    checkOutput($sformatf("v%0d_re", n), 32'(reg_re_o), 32'(v.exp_re));
    checkOutput($sformatf("v%0d_ready_access", n), 32'(req_ready_o), 32'd0);
    checkOutput($sformatf("v%0d_valid_access", n), 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i);
    checkOutput($sformatf("v%0d_rsp_valid", n), 32'(rsp_valid_o), 32'd1);
    checkOutput($sformatf("v%0d_rdata", n), rsp_rdata_o, v.exp_rdata);
    checkOutput($sformatf("v%0d_err", n), 32'(rsp_error_o), 32'(v.exp_err));
    checkOutput($sformatf("v%0d_we_resp", n), 32'(reg_we_o), 32'd0);
    @(negedge clk_i);
    checkOutput($sformatf("v%0d_valid_after", n), 32'(rsp_valid_o), 32'd0);
    checkOutput($sformatf("v%0d_ready_after", n), 32'(req_ready_o), 32'd1);
  endtask

  initial begin
    int bad;
    int pulses;

    //            addr   wr    wdata         be       qs            we        wd            re        rdata         err
    vecs[0] = '{5'h04, 1'b1, 32'hDEADBEEF, 4'hF, 32'h00000000, 7'h02, 32'hDEADBEEF, 7'h00, 32'h00000000, 1'b0};
    vecs[1] = '{5'h08, 1'b1, 32'h1234ABCD, 4'h3, 32'hFFFF0000, 7'h04, 32'hFFFFABCD, 7'h00, 32'h00000000, 1'b0};
    vecs[2] = '{5'h00, 1'b1, 32'hCAFEF00D, 4'hA, 32'h11223344, 7'h01, 32'hCA22F044, 7'h00, 32'h00000000, 1'b0};
    vecs[3] = '{5'h10, 1'b1, 32'h00000055, 4'h0, 32'h00000077, 7'h00, 32'h00000077, 7'h00, 32'h00000000, 1'b0};
    vecs[4] = '{5'h14, 1'b0, 32'h00000000, 4'h0, 32'h89ABCDEF, 7'h00, 32'h00000000, 7'h00, 32'h89ABCDEF, 1'b0};
    vecs[5] = '{5'h18, 1'b0, 32'hFFFFFFFF, 4'hF, 32'h0F0F0F0F, 7'h00, 32'h00000000, 7'h00, 32'h0F0F0F0F, 1'b0};
    vecs[6] = '{5'h05, 1'b0, 32'h00000000, 4'h0, 32'hFFFFFFFF, 7'h00, 32'h00000000, 7'h00, 32'h00000000, 1'b1};
    vecs[7] = '{5'h1C, 1'b1, 32'h12345678, 4'hF, 32'h00000000, 7'h00, 32'h00000000, 7'h00, 32'h00000000, 1'b1};
    vecs[8] = '{5'h1C, 1'b0, 32'h00000000, 4'h0, 32'h00000000, 7'h00, 32'h00000000, 7'h00, 32'h00000000, 1'b1};
    vecs[9] = '{5'h1A, 1'b1, 32'hA5A5A5A5, 4'hF, 32'h33333333, 7'h00, 32'h00000000, 7'h00, 32'h00000000, 1'b1};

    for (int i = 0; i < NREGS; i++) qs_arr[i] = 32'h0;
    rst_i       = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i  = '0;
    req_write_i = 1'b0;
    req_wdata_i = '0;
    req_be_i    = '0;
    rsp_ready_i = 1'b1;

    // Reset state
    repeat (2) @(negedge clk_i);
    checkOutput("rst_ready", 32'(req_ready_o), 32'd0);
    checkOutput("rst_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("rst_rdata", rsp_rdata_o, 32'd0);
    checkOutput("rst_err", 32'(rsp_error_o), 32'd0);
    checkOutput("rst_we", 32'(reg_we_o), 32'd0);
    checkOutput("rst_re", 32'(reg_re_o), 32'd0);
    checkOutput("rst_wd", reg_wd_o, 32'd0);
    rst_i = 1'b0;

    // Table-driven transactions
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Read-clear register returns the pre-clear value
    qs_arr[3]   = 32'hA5A5A5A5;
    req_addr_i  = 5'h0C;
    req_write_i = 1'b0;
    req_be_i    = 4'h0;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("rc_re_pulse", 32'(reg_re_o), 32'h08);
    checkOutput("rc_we", 32'(reg_we_o), 32'd0);
    @(posedge clk_i);
    #1 qs_arr[3] = 32'h0;
    @(negedge clk_i);
    checkOutput("rc_re_resp", 32'(reg_re_o), 32'd0);
    checkOutput("rc_rdata", rsp_rdata_o, 32'hA5A5A5A5);
    checkOutput("rc_err", 32'(rsp_error_o), 32'd0);
    @(negedge clk_i);

    // Backpressure with a second request pending
    rsp_ready_i = 1'b0;
    qs_arr[5]   = 32'h5A5A1234;
    req_addr_i  = 5'h04;
    req_write_i = 1'b1;
    req_wdata_i = 32'h00000001;
    req_be_i    = 4'hF;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_addr_i  = 5'h14;
    req_write_i = 1'b0;
    req_be_i    = 4'h0;
    @(negedge clk_i);
    checkOutput("bp_we", 32'(reg_we_o), 32'h02);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o !== 1'b1 || req_ready_o !== 1'b0 || rsp_error_o !== 1'b0 ||
          rsp_rdata_o !== 32'h0 || reg_we_o !== '0 || reg_re_o !== '0) bad++;
    end
    checkOutput("bp_stable_cycles_bad", 32'(bad), 32'd0);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bp_release_valid", 32'(rsp_valid_o), 32'd0);
    checkOutput("bp_release_ready", 32'(req_ready_o), 32'd1);
    checkOutput("bp_release_re", 32'(reg_re_o), 32'd0);
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("bp_next_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    checkOutput("bp_next_valid", 32'(rsp_valid_o), 32'd1);
    checkOutput("bp_next_rdata", rsp_rdata_o, 32'h5A5A1234);
    @(negedge clk_i);

    // Reset asserted in the ACCESS cycle
    qs_arr[1]   = 32'h0;
    req_addr_i  = 5'h04;
    req_write_i = 1'b1;
    req_wdata_i = 32'hFFFFFFFF;
    req_be_i    = 4'hF;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("mrst_we", 32'(reg_we_o), 32'd0);
    checkOutput("mrst_wd", reg_wd_o, 32'd0);
    checkOutput("mrst_ready", 32'(req_ready_o), 32'd0);
    @(negedge clk_i);
    checkOutput("mrst_valid_in_rst", 32'(rsp_valid_o), 32'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("mrst_ready_after", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    checkOutput("mrst_no_rsp", 32'(rsp_valid_o), 32'd0);
    checkOutput("mrst_no_we", 32'(reg_we_o), 32'd0);

    // Throughput with request and response ready held high
    req_addr_i  = 5'h10;
    req_write_i = 1'b1;
    req_wdata_i = 32'h0000BEEF;
    req_be_i    = 4'hF;
    req_valid_i = 1'b1;
    pulses = 0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_i);
      if (reg_we_o != '0) pulses++;
    end
    req_valid_i = 1'b0;
    checkOutput("throughput_pulses", 32'(pulses), 32'd3);
    @(negedge clk_i);
    checkOutput("throughput_idle", 32'(req_ready_o), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iommu_reg_if_slave.md
# iommu_reg_if_slave

Register-interface front-end for the IOMMU register file. It accepts single-beat read and write requests from the programming bus and decodes each one to a register index. It then drives the software-side write strobes (`we`/`wd`) of the register fields and the read pulses used by read-clear fields, and samples the fields' software-visible values (`qs`) to return read data. Each transaction is held in a three-state FSM and returned over a valid/ready response channel.

## Interface
Parameters:
- `NREGS`, 8: number of 32-bit registers decoded.
- `AW`, 5: byte-address width; must satisfy 2^(AW-2) >= NREGS.
- `DW`, 32: register/data width; fixed at 32.
- `RC_MASK`, '0: NREGS-bit mask; bit i set means register i is read-clear and gets a read pulse.

Ports:
- `clk_i` input 1: clock.
- `rst_i` input 1: reset, synchronous, active-high.
- `req_valid_i` input 1: request valid.
- `req_ready_o` output 1: request accepted when valid && ready.
- `req_addr_i` input AW: byte address.
- `req_write_i` input 1: 1 = write, 0 = read.
- `req_wdata_i` input DW: write data.
- `req_be_i` input DW/8: byte enables for writes.
- `rsp_valid_o` output 1: response valid.
- `rsp_ready_i` input 1: response consumed when valid && ready.
- `rsp_rdata_o` output DW: read data; 0 for writes and errors.
- `rsp_error_o` output 1: decode error.
- `reg_we_o` output NREGS: one-hot write strobe to field `we` inputs.
- `reg_wd_o` output DW: merged write data to field `wd` inputs.
- `reg_re_o` output NREGS: one-hot read pulse, restricted to RC_MASK registers.
- `reg_qs_i` input NREGS*DW: concatenated field `qs`; register i occupies bits [i*DW +: DW].

## Operation
- FSM states and transitions:
  - IDLE → ACCESS on request handshake.
  - ACCESS → RESP unconditionally.
  - RESP → IDLE on response handshake.
- `req_ready_o` = (state==IDLE) && !rst_i.
- On accept, capture addr, write, wdata and be.
- Index decode: idx = addr[AW-1:2].
- Error conditions: addr[1:0]!=0, or idx>=NREGS. On error, no strobe is issued, `rsp_error_o`=1 and `rsp_rdata_o`=0.
- ACCESS cycle, write, no error:
  - `reg_we_o[idx]`=1 for exactly one cycle.
  - `reg_wd_o` = (qs[idx] & ~M) | (wdata & M), where M expands each be bit to 8 bits.
  - be==0 issues no strobe and still completes without error.
- ACCESS cycle, read, no error:
  - Capture qs[idx] into the response data register.
  - If RC_MASK[idx], pulse `reg_re_o[idx]` for one cycle.
  - Captured data is the pre-clear value, because fields update on the following edge.
- RESP: `rsp_valid_o`, `rsp_rdata_o` and `rsp_error_o` are held stable until `rsp_ready_i`.
- `reg_we_o`, `reg_re_o` and `reg_wd_o` are 0 outside ACCESS.
- Reset values: state IDLE; `req_ready_o`=0 while `rst_i`=1 and 1 in the first cycle after; `rsp_valid_o`=0; `rsp_rdata_o`=0; `rsp_error_o`=0; `reg_we_o`=0; `reg_re_o`=0; `reg_wd_o`=0.
- Reset asserted mid-transaction: the transaction is dropped with no response. A strobe that would occur in the reset cycle is suppressed.

## Timing
- Handshake at edge N → ACCESS strobe in cycle N+1 → `rsp_valid_o` high from cycle N+2.
- Minimum 3 cycles per transaction. No overlap: `req_ready_o`=0 in ACCESS and RESP.
- Response handshake and new request in the same cycle: the response completes, and the new request is accepted no earlier than the next cycle, in IDLE.
- `rsp_ready_i` held high → one transaction every 3 cycles.
- `rsp_ready_i` low → RESP holds indefinitely with outputs unchanged.
- Strobe outputs are registered from the state; no combinational path from `req_*` to `reg_*`.
- Requester obligation: `req_*` must be stable while valid && !ready. This block does not check it.

## Test plan
- Write addr 0x04, wdata 0xDEADBEEF, be 0xF, reg1 qs=0 → `reg_we_o`=0x02 and `reg_wd_o`=0xDEADBEEF for one cycle at N+1; response at N+2 with error 0 and rdata 0.
- Partial write addr 0x08, be 0x3, wdata 0x1234ABCD, reg2 qs=0xFFFF0000 → `reg_wd_o`=0xFFFFABCD.
- Read addr 0x0C, reg3 qs=0xA5A5A5A5, RC_MASK bit3=1 → `reg_re_o`=0x08 for one cycle; `rsp_rdata_o`=0xA5A5A5A5 even though qs becomes 0 afterwards.
- Misaligned addr 0x05, and out-of-range addr 0x1C with NREGS=7 → no strobes; `rsp_error_o`=1, rdata 0.
- Backpressure: hold `rsp_ready_i`=0 for 10 cycles → response stable, `req_ready_o`=0 throughout; release → IDLE the next cycle, then accept the next request.
- Assert `rst_i` in the ACCESS cycle → no strobe that cycle, no response, and `req_ready_o`=1 in the first cycle after reset deasserts.
